hsv_to_rgb: RTL and testbench

Pipelined HSV-to-RGB reconstruction for the skin-detection datapath. It turns a hue (sector plus fraction), saturation and value back into 10-bit RGB. It sits after the skin classifier and drives the overlay/debug video path, so classified or recoloured pixels can be shown on the RGB display. It is the inverse of the RGB-to-hue front end: the sector encodes which channel is max, and the fraction encodes the inter-channel difference.

---
 rtl/hsv_to_rgb_pkg.sv | 29 ++
 rtl/hsv_to_rgb_if.sv | 28 ++
 rtl/hsv_to_rgb_sector_mux.sv | 36 +++
 rtl/hsv_to_rgb.sv | 123 ++++++++++++
 tb/tb_hsv_to_rgb.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/hsv_to_rgb_pkg.sv
// hsv_pkg: widths and sector encoding shared by the HSV-to-RGB back end and
// the RGB-to-hue front end, so both directions agree on which sector means
// which channel is the maximum.
//   CH_W    colour channel width
//   FRAC_W  hue fraction width (f/1024)
//   SEC_W   hue sector width; legal sectors are 0..SEC_MAX
package hsv_pkg;

  localparam int unsigned CH_W   = 10;
  localparam int unsigned FRAC_W = 10;
  localparam int unsigned SEC_W  = 3;

  // Sector names: the pair of channels the hue lies between.
  typedef enum logic [SEC_W-1:0] {
    SEC_RY = 3'd0,
    SEC_YG = 3'd1,
    SEC_GC = 3'd2,
    SEC_CB = 3'd3,
    SEC_BM = 3'd4,
    SEC_MR = 3'd5
  } sector_e;

  localparam logic [SEC_W-1:0] SEC_MAX = SEC_MR;

  typedef logic [CH_W-1:0]   ch_t;
  typedef logic [FRAC_W-1:0] frac_t;
  typedef logic [SEC_W-1:0]  sec_t;

endpackage

// File: rtl/hsv_to_rgb_if.sv
// hsv_to_rgb_if: pixel bus into and out of the HSV-to-RGB converter.
//   in_valid/sector/frac/sat/val  HSV pixel from the classifier side
//   red/green/blue/out_valid/out_err  reconstructed RGB pixel
// master: upstream/downstream user of the converter; slave: the converter.
interface hsv_to_rgb_if
  import hsv_pkg::*;
();
  logic  in_valid;
  sec_t  sector;
  frac_t frac;
  ch_t   sat;
  ch_t   val;
  ch_t   red;
  ch_t   green;
  ch_t   blue;
  logic  out_valid;
  logic  out_err;

  modport master (
    output in_valid, sector, frac, sat, val,
    input  red, green, blue, out_valid, out_err
  );

  modport slave (
    input  in_valid, sector, frac, sat, val,
    output red, green, blue, out_valid, out_err
  );
endinterface

// File: rtl/hsv_to_rgb_sector_mux.sv
// hsv_sector_mux: combinational channel selection by hue sector.
//   sector_i        hue sector 0..5 (6,7 illegal)
//   v_i,p_i,q_i,t_i candidate channel values
//   r_o,g_o,b_o     selected RGB; all zero for an illegal sector
//   err_o           high for an illegal sector
module hsv_sector_mux
  import hsv_pkg::*;
(
  input  sec_t sector_i,
  input  ch_t  v_i,
  input  ch_t  p_i,
  input  ch_t  q_i,
  input  ch_t  t_i,
  output ch_t  r_o,
  output ch_t  g_o,
  output ch_t  b_o,
  output logic err_o
);

  always_comb begin
    r_o   = '0;
    g_o   = '0;
    b_o   = '0;
    err_o = (sector_i > SEC_MAX);
    case (sector_i)
      SEC_RY:  begin r_o = v_i; g_o = t_i; b_o = p_i; end
      SEC_YG:  begin r_o = q_i; g_o = v_i; b_o = p_i; end
      SEC_GC:  begin r_o = p_i; g_o = v_i; b_o = t_i; end
      SEC_CB:  begin r_o = p_i; g_o = q_i; b_o = v_i; end
      SEC_BM:  begin r_o = t_i; g_o = p_i; b_o = v_i; end
      SEC_MR:  begin r_o = v_i; g_o = p_i; b_o = q_i; end
      default: begin r_o = '0;  g_o = '0;  b_o = '0;  end
    endcase
  end

endmodule

// File: rtl/hsv_to_rgb.sv
// hsv_to_rgb: three-stage HSV-to-RGB reconstruction, truncating arithmetic.
//   clk    pixel clock
//   rst_n  asynchronous active-low reset; clears all stages and outputs
//   ce     pipeline advance enable; all registers hold while low
//   bus    hsv_to_rgb_if.slave pixel bus (HSV in, RGB out)
// Latency is three ce=1 edges; one pixel per ce=1 edge.
module hsv_to_rgb
  import hsv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  hsv_to_rgb_if.slave  bus
);

  // S1: registered inputs
  logic  s1_vld_q;
  sec_t  s1_sec_q;
  frac_t s1_frac_q;
  ch_t   s1_sat_q;
  ch_t   s1_val_q;
  logic [2*CH_W-1:0] vs_d;

  // S2: registered product and operands
  logic  s2_vld_q;
  sec_t  s2_sec_q;
  frac_t s2_frac_q;
  ch_t   s2_val_q;
  logic [2*CH_W-1:0] s2_vs_q;

  logic [FRAC_W:0]   omf;
  logic [29:0]       qp;
  logic [30:0]       tp;
  ch_t               p_d, q_d, t_d;

  // S3: outputs
  ch_t  mux_r, mux_g, mux_b;
  logic mux_err;
  ch_t  red_q, green_q, blue_q;
  ch_t  red_d, green_d, blue_d;
  logic vld_q, err_q, err_d;

  assign vs_d = (2*CH_W)'(s1_val_q) * (2*CH_W)'(s1_sat_q);

  // p,q,t never exceed val, so plain subtraction cannot wrap.
  always_comb begin
    omf = 11'd1024 - {1'b0, s2_frac_q};
    qp  = 30'(s2_vs_q) * 30'(s2_frac_q);
    tp  = 31'(s2_vs_q) * 31'(omf);
    p_d = s2_val_q - CH_W'(s2_vs_q >> 10);
    q_d = s2_val_q - CH_W'(qp >> 20);
    t_d = s2_val_q - CH_W'(tp >> 20);
  end

  hsv_sector_mux u_mux (
    .sector_i (s2_sec_q),
    .v_i      (s2_val_q),
    .p_i      (p_d),
    .q_i      (q_d),
    .t_i      (t_d),
    .r_o      (mux_r),
    .g_o      (mux_g),
    .b_o      (mux_b),
    .err_o    (mux_err)
  );

  // Output data only moves on a valid pixel; bubbles keep the last value.
  always_comb begin
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    err_d   = err_q;
    if (s2_vld_q) begin
      red_d   = mux_r;
      green_d = mux_g;
      blue_d  = mux_b;
      err_d   = mux_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_sec_q  <= '0;
      s1_frac_q <= '0;
      s1_sat_q  <= '0;
      s1_val_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_sec_q  <= '0;
      s2_frac_q <= '0;
      s2_val_q  <= '0;
      s2_vs_q   <= '0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
    end else if (ce) begin
      s1_vld_q  <= bus.in_valid;
      s1_sec_q  <= bus.sector;
      s1_frac_q <= bus.frac;
      s1_sat_q  <= bus.sat;
      s1_val_q  <= bus.val;
      s2_vld_q  <= s1_vld_q;
      s2_sec_q  <= s1_sec_q;
      s2_frac_q <= s1_frac_q;
      s2_val_q  <= s1_val_q;
      s2_vs_q   <= vs_d;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
      vld_q     <= s2_vld_q;
      err_q     <= err_d;
    end
  end

  assign bus.red       = red_q;
  assign bus.green     = green_q;
  assign bus.blue      = blue_q;
  assign bus.out_valid = vld_q;
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_hsv_to_rgb.sv
// tb_hsv_to_rgb: directed self-checking bench for hsv_to_rgb.
module tb_hsv_to_rgb;
  import hsv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;

  hsv_to_rgb_if bus ();

  hsv_to_rgb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic       v;
    logic [2:0] s;
    logic [9:0] f, sa, va, r, g, b;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [9:0] f,
                       input logic [9:0] sa, input logic [9:0] va);
    bus.in_valid = v;
    bus.sector   = s;
    bus.frac     = f;
    bus.sat      = sa;
    bus.val      = va;
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic err,
                         input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(vld));
    chk({tag, ".err"},   32'(bus.out_err),   32'(err));
    chk({tag, ".red"},   32'(bus.red),       32'(r));
    chk({tag, ".green"}, 32'(bus.green),     32'(g));
    chk({tag, ".blue"},  32'(bus.blue),      32'(b));
  endtask

  // One pixel followed by bubbles; checks exact three-edge latency.
  task automatic pix(input string tag, input logic [2:0] s, input logic [9:0] f,
                     input logic [9:0] sa, input logic [9:0] va, input logic err,
                     input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    ce = 1'b1;
    drive(1'b1, s, f, sa, va);
    tick();
    drive(1'b0, 3'd0, 10'd0, 10'd0, 10'd0);
    tick();
    chk({tag, ".early"}, 32'(bus.out_valid), 32'd0);
    tick();
    chk_out(tag, 1'b1, err, r, g, b);
  endtask

  function automatic vec_t mk(input logic v, input logic [2:0] s, input logic [9:0] f,
                              input logic [9:0] sa, input logic [9:0] va,
                              input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    vec_t x;
    x.v = v; x.s = s; x.f = f; x.sa = sa; x.va = va; x.r = r; x.g = g; x.b = b;
    return x;
  endfunction

  initial begin
    logic [9:0] lr, lg, lb, fr;
    logic       fv;
    int unsigned nedge;

    drive(1'b0, 3'd0, 10'd0, 10'd0, 10'd0);
    #12;
    chk_out("reset", 1'b0, 1'b0, 10'd0, 10'd0, 10'd0);
    rst_n = 1'b1;
    ce = 1'b1;
    tick();

    pix("s0",     3'd0, 10'd256, 10'd512, 10'd1000, 1'b0, 10'd1000, 10'd625, 10'd500);
    tick();
    chk_out("bubble_hold", 1'b0, 1'b0, 10'd1000, 10'd625, 10'd500);
    pix("s3",     3'd3, 10'd256, 10'd512, 10'd1000, 1'b0, 10'd500,  10'd875, 10'd1000);
    pix("s1_max", 3'd1, 10'd0,   10'd1023, 10'd1023, 1'b0, 10'd1023, 10'd1023, 10'd1);
    pix("s0_f1023", 3'd0, 10'd1023, 10'd1023, 10'd1023, 1'b0, 10'd1023, 10'd1023, 10'd1);
    for (int s = 0; s < 6; s++)
      pix($sformatf("grey%0d", s), 3'(s), 10'($urandom_range(0, 1023)), 10'd0, 10'd700,
          1'b0, 10'd700, 10'd700, 10'd700);
    pix("sec6", 3'd6, 10'd100, 10'd300, 10'd900, 1'b1, 10'd0, 10'd0, 10'd0);
    pix("sec7", 3'd7, 10'd100, 10'd300, 10'd900, 1'b1, 10'd0, 10'd0, 10'd0);
    pix("val0", 3'd2, 10'd500, 10'd800, 10'd0,   1'b0, 10'd0, 10'd0, 10'd0);
    tick(); tick(); tick();

    // Stream with random ce stalls and a bubble in slot 4, then a flush.
    tbl[0]  = mk(1'b1, 3'd0, 10'd256, 10'd512, 10'd1000, 10'd1000, 10'd625, 10'd500);
    tbl[1]  = mk(1'b1, 3'd1, 10'd256, 10'd512, 10'd1000, 10'd875, 10'd1000, 10'd500);
    tbl[2]  = mk(1'b1, 3'd2, 10'd256, 10'd512, 10'd1000, 10'd500, 10'd1000, 10'd625);
    tbl[3]  = mk(1'b1, 3'd3, 10'd256, 10'd512, 10'd1000, 10'd500, 10'd875, 10'd1000);
    tbl[4]  = mk(1'b0, 3'd0, 10'd0,   10'd0,   10'd0,    10'd0,   10'd0,   10'd0);
    tbl[5]  = mk(1'b1, 3'd4, 10'd256, 10'd512, 10'd1000, 10'd625, 10'd500, 10'd1000);
    tbl[6]  = mk(1'b1, 3'd5, 10'd256, 10'd512, 10'd1000, 10'd1000, 10'd500, 10'd875);
    tbl[7]  = mk(1'b1, 3'd1, 10'd0,   10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1);
    tbl[8]  = mk(1'b1, 3'd5, 10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1, 10'd2);
    for (int i = 9; i < 12; i++) tbl[i] = tbl[4];

    lr = 10'd0; lg = 10'd0; lb = 10'd0;
    fv = bus.out_valid; fr = bus.red;
    nedge = 0;
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].f, tbl[i].sa, tbl[i].va);
      repeat ($urandom_range(0, 2)) begin
        ce = 1'b0;
        tick();
        chk($sformatf("stall%0d.valid", i), 32'(bus.out_valid), 32'(fv));
        chk($sformatf("stall%0d.red", i),   32'(bus.red),       32'(fr));
      end
      ce = 1'b1;
      tick();
      nedge++;
      if (nedge >= 3) begin
        int unsigned k;
        k = nedge - 3;
        if (tbl[k].v) begin
          lr = tbl[k].r; lg = tbl[k].g; lb = tbl[k].b;
        end
        chk_out($sformatf("stream%0d", k), tbl[k].v, 1'b0, lr, lg, lb);
      end else begin
        chk($sformatf("stream_fill%0d", nedge), 32'(bus.out_valid), 32'd0);
      end
      fv = bus.out_valid; fr = bus.red;
    end

    // Asynchronous reset in the middle of a valid stream.
    ce = 1'b1;
    drive(1'b1, 3'd0, 10'd256, 10'd512, 10'd1000);
    tick(); tick(); tick(); tick();
    chk_out("pre_rst", 1'b1, 1'b0, 10'd1000, 10'd625, 10'd500);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 1'b0, 10'd0, 10'd0, 10'd0);
    drive(1'b0, 3'd0, 10'd0, 10'd0, 10'd0);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_rst%0d.valid", i), 32'(bus.out_valid), 32'd0);
      chk($sformatf("post_rst%0d.red", i),   32'(bus.red),       32'd0);
    end
    pix("recover", 3'd4, 10'd256, 10'd512, 10'd1000, 1'b0, 10'd625, 10'd500, 10'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
